ntt_core_param: RTL and testbench

//  Parametrised N-point number-theoretic transform (forward and inverse) over Z_Q.

---
 rtl/ntt_core_param.sv | 226 ++++++++++++++++++++++
 tb/tb_ntt_core_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_core_param.sv
// Streaming N-point NTT / inverse NTT over Z_Q.
// Bit-reversed load, in-place radix-2 DIT, one butterfly per cycle.
module ntt_core_param #(
  parameter int DATA_WIDTH = 32,
  parameter int N = 8,
  parameter int LOG2N = 3,
  parameter logic [DATA_WIDTH-1:0] Q = 17,
  parameter logic [DATA_WIDTH-1:0] OMEGA = 2,
  parameter logic [DATA_WIDTH-1:0] OMEGA_INV = 9,
  parameter logic [DATA_WIDTH-1:0] N_INV = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LOG2N-1:0]      out_index,
  output logic                  busy,
  output logic                  done
);

  localparam int HALF = N / 2;
  localparam int EW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW2 = 2 * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [DW2-1:0] dword_t;
  typedef logic [HALF-1:0][DATA_WIDTH-1:0] tw_tab_t;
  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT
  } state_t;

  localparam dword_t Q2 = dword_t'(Q);

  function automatic dword_t ext(input word_t x);
    return {{DATA_WIDTH{1'b0}}, x};
  endfunction

  function automatic word_t mulmod(input word_t a, input word_t b);
    dword_t p;
    p = (ext(a) * ext(b)) % Q2;
    return p[DATA_WIDTH-1:0];
  endfunction

  // Powers W^e for e < N/2; every stage's twiddle is one of these.
  function automatic tw_tab_t gen_tw(input word_t w);
    tw_tab_t t;
    word_t acc;
    acc = word_t'(1);
    for (int e = 0; e < HALF; e++) begin
      t[e] = acc;
      acc = mulmod(acc, w);
    end
    return t;
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] k
  );
    logic [LOG2N-1:0] rv;
    for (int i = 0; i < LOG2N; i++) begin
      rv[i] = k[LOG2N-1-i];
    end
    return rv;
  endfunction

  localparam tw_tab_t TW_FWD = gen_tw(OMEGA);
  localparam tw_tab_t TW_INV = gen_tw(OMEGA_INV);

  state_t r_state;
  state_t w_next;

  word_t r_mem [N];

  logic [LOG2N-1:0] r_cnt;
  logic [SW-1:0]    r_stage;
  logic [EW-1:0]    r_bfly;
  logic             r_mode;
  logic             r_out_valid;
  word_t            r_out_data;
  logic [LOG2N-1:0] r_out_index;
  logic             r_done;

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_last_bf;
  logic [LOG2N-1:0] w_m;
  logic [LOG2N-1:0] w_h;
  logic [LOG2N-1:0] w_j;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_b;
  logic [EW-1:0]    w_e;
  word_t            w_tw;
  word_t            w_va;
  word_t            w_vb;
  word_t            w_t;
  word_t            w_sum;
  word_t            w_dif;
  word_t            w_new_a;
  word_t            w_new_b;
  word_t            w_in_red;
  word_t            w_rd_raw;
  word_t            w_out_next;

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign done      = r_done;

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_out_valid & out_ready;
  assign w_in_red = in_data % Q;

  assign w_last_bf = (r_state == S_COMPUTE)
                   & (r_stage == SW'(LOG2N - 1))
                   & (&r_bfly);

  always_comb begin
    w_m = LOG2N'(r_bfly);
    w_h = LOG2N'(1) << r_stage;
    w_j = w_m & (w_h - LOG2N'(1));
    w_a = ((w_m >> r_stage) << (r_stage + 1)) | w_j;
    w_b = w_a + w_h;
    w_e = EW'(w_j << (EW - r_stage));
    w_tw = r_mode ? TW_INV[w_e] : TW_FWD[w_e];
    w_va = r_mem[w_a];
    w_vb = r_mem[w_b];
    w_t = mulmod(w_tw, w_vb);
    w_sum = w_va + w_t;
    w_new_a = (w_sum >= Q) ? w_sum - Q : w_sum;
    w_dif = w_va + (Q - w_t);
    w_new_b = (w_dif >= Q) ? w_dif - Q : w_dif;
  end

  // Word 0 may be rewritten by the final butterfly; forward it.
  always_comb begin
    w_rd_raw = r_mem[r_out_index + 1'b1];
    if (r_state == S_COMPUTE) begin
      w_rd_raw = (w_a == '0) ? w_new_a : r_mem[0];
    end
    w_out_next = r_mode ? mulmod(w_rd_raw, N_INV) : w_rd_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD: begin
        if (w_in_hs && (&r_cnt)) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (w_last_bf) w_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (w_out_hs && (&r_out_index)) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_mem[bitrev(r_cnt)] <= w_in_red;
    end else if (r_state == S_COMPUTE) begin
      r_mem[w_a] <= w_new_a;
      r_mem[w_b] <= w_new_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_stage     <= '0;
      r_bfly      <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_hs) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '0) r_mode <= in_mode;
      end
      if (r_state == S_COMPUTE) begin
        r_bfly <= r_bfly + 1'b1;
        if (&r_bfly) begin
          r_stage <= w_last_bf ? '0 : r_stage + 1'b1;
        end
        if (w_last_bf) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_out_next;
          r_out_index <= '0;
        end
      end
      if (w_out_hs) begin
        if (&r_out_index) begin
          r_out_valid <= 1'b0;
          r_done      <= 1'b1;
          r_out_index <= '0;
        end else begin
          r_out_index <= r_out_index + 1'b1;
          r_out_data  <= w_out_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_core_param.sv
// Directed bench for ntt_core_param (N=8, Q=17).
// Expected values are hand constants or a naive O(N^2) DFT model.
module tb_ntt_core_param;

  localparam int DW = 32;
  localparam int N = 8;
  localparam int LG = 3;

  typedef int unsigned vec_t [N];

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [LG-1:0] out_index;
  logic          busy;
  logic          done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;

  ntt_core_param dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned pw(
    input int unsigned b,
    input int unsigned e
  );
    longint unsigned r;
    r = 1;
    for (int i = 0; i < int'(e); i++) r = (r * b) % 17;
    return int'(r);
  endfunction

  function automatic vec_t dft(input vec_t x, input bit inv);
    vec_t y;
    longint unsigned acc;
    int unsigned w;
    w = inv ? 9 : 2;
    for (int k = 0; k < N; k++) begin
      acc = 0;
      for (int n = 0; n < N; n++) begin
        acc = (acc + (x[n] % 17) * pw(w, n * k)) % 17;
      end
      if (inv) acc = (acc * 15) % 17;
      y[k] = int'(acc);
    end
    return y;
  endfunction

  // in_mode is flipped after word 0 to show it is only latched there.
  task automatic send(input vec_t x, input bit mode);
    int t;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = x[k];
      in_mode  = (k == 0) ? mode : ~mode;
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("in_ready_wait", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_mode  = 1'b0;
  endtask

  task automatic recv(
    input vec_t  exp,
    input bit    rnd,
    input bit    stall,
    input bit    lat_chk,
    input string nm
  );
    int lat;
    int i;
    int g;
    int st;
    int d0;
    logic rdy;
    d0 = done_cnt;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_ovalid_first"}, out_valid, 1);
    if (lat_chk) chk({nm, "_latency"}, lat, 13);
    i = 0;
    g = 0;
    st = 0;
    while (i < N && g < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && i == 3 && st < 5) begin
        rdy = 1'b0;
        st++;
      end
      out_ready = rdy;
      chk($sformatf("%s_ovalid%0d", nm, i), out_valid, 1);
      chk($sformatf("%s_idx%0d", nm, i), out_index, i);
      chk($sformatf("%s_dat%0d", nm, i), out_data, exp[i]);
      if (rdy && out_valid) i++;
      @(negedge clk);
      g++;
    end
    chk({nm, "_words"}, i, N);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_ovalid_end"}, out_valid, 0);
    chk({nm, "_in_ready_end"}, in_ready, 1);
    out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done_clr"}, done, 0);
    @(negedge clk);
    chk({nm, "_done_cnt"}, done_cnt - d0, 1);
  endtask

  vec_t x;
  vec_t y;
  vec_t e;
  vec_t x20;
  vec_t x3;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    reset = 1'b0;
    @(negedge clk);

    x = '{1, 0, 0, 0, 0, 0, 0, 0};
    e = '{1, 1, 1, 1, 1, 1, 1, 1};
    send(x, 1'b0);
    recv(e, 1'b0, 1'b0, 1'b1, "t1");

    x = '{0, 1, 0, 0, 0, 0, 0, 0};
    e = '{1, 2, 4, 8, 16, 15, 13, 9};
    send(x, 1'b0);
    recv(e, 1'b0, 1'b0, 1'b0, "t2");

    x = '{1, 1, 1, 1, 1, 1, 1, 1};
    e = '{8, 0, 0, 0, 0, 0, 0, 0};
    send(x, 1'b0);
    recv(e, 1'b0, 1'b0, 1'b0, "t3f");
    x = '{8, 0, 0, 0, 0, 0, 0, 0};
    e = '{1, 1, 1, 1, 1, 1, 1, 1};
    send(x, 1'b1);
    recv(e, 1'b0, 1'b0, 1'b0, "t3i");

    for (int k = 0; k < N; k++) x[k] = $urandom_range(0, 16);
    y = dft(x, 1'b0);
    send(x, 1'b0);
    recv(y, 1'b0, 1'b0, 1'b0, "t4f");
    send(y, 1'b1);
    recv(x, 1'b0, 1'b0, 1'b0, "t4i");

    x20 = '{20, 5, 33, 0, 16, 17, 1, 40};
    x3  = '{3, 5, 16, 0, 16, 0, 1, 6};
    send(x20, 1'b0);
    recv(dft(x3, 1'b0), 1'b0, 1'b0, 1'b0, "t4r");

    for (int k = 0; k < N; k++) x[k] = $urandom_range(0, 16);
    send(x, 1'b0);
    recv(dft(x, 1'b0), 1'b1, 1'b1, 1'b1, "t5");

    for (int k = 0; k < N; k++) x[k] = $urandom_range(0, 40);
    send(x, 1'b0);
    repeat (5) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_valid", out_valid, 0);
    begin
      int d0;
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_idle_valid", out_valid, 0);
    end
    for (int k = 0; k < N; k++) x[k] = $urandom_range(0, 16);
    send(x, 1'b1);
    recv(dft(x, 1'b1), 1'b0, 1'b0, 1'b1, "t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
